game_flow_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 31 +++
 rtl/game_flow_ctrl_frame_counter.sv | 39 +++
 rtl/game_flow_ctrl.sv | 169 ++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the round sequencer.
package game_pkg;

   localparam int unsigned BCD_W     = 4;
   localparam int unsigned CNT_W     = 8;
   localparam logic [7:0]  SCORE_MAX = 8'h99;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StReady = 3'd1,
      StPlay  = 3'd2,
      StHit   = 3'd3,
      StOver  = 3'd4
   } game_state_e;

   // Two-digit BCD increment that sticks at 99.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] units;
      tens  = v[7:4];
      units = v[3:0];
      if (v == SCORE_MAX) begin
         return SCORE_MAX;
      end else if (units == 4'd9) begin
         return {tens + 4'd1, 4'd0};
      end else begin
         return {tens, units + 4'd1};
      end
   endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_counter.sv
// Frame counter: counts enable pulses up to a runtime limit, wraps and flags done.
module frame_counter
   import game_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count_next,
   output logic             done
);

   logic [CNT_W-1:0] count;
   logic             at_term;

   assign at_term = (count == limit - CNT_W'(1));
   assign done    = enable & at_term & ~clear;

   // Next count: clear wins, otherwise advance on enable and wrap at the limit.
   always_comb begin
      count_next = count;
      if (clear) begin
         count_next = '0;
      end else if (enable) begin
         count_next = at_term ? '0 : count + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Round sequencer: idle, countdown, play, hit-freeze, game-over; score and high score.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int unsigned READY_FRAMES = 90,
   parameter int unsigned HIT_FRAMES   = 60,
   parameter int unsigned BLINK_FRAMES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_of_frame,
   input  logic       start_key,
   input  logic       collision_bird,
   input  logic       bird_game_over,
   input  logic       pipe_passed,
   output logic       bird_resetN,
   output logic       move_enable,
   output logic [7:0] score_bcd,
   output logic [7:0] high_bcd,
   output logic [2:0] state,
   output logic       show_over,
   output logic [1:0] countdown
);

   localparam logic [CNT_W-1:0] READY_LIM = CNT_W'(READY_FRAMES);
   localparam logic [CNT_W-1:0] HIT_LIM   = CNT_W'(HIT_FRAMES);
   localparam logic [CNT_W-1:0] BLINK_LIM = CNT_W'(BLINK_FRAMES);
   localparam logic [CNT_W-1:0] THIRD_1   = CNT_W'(READY_FRAMES / 3);
   localparam logic [CNT_W-1:0] THIRD_2   = CNT_W'(2 * (READY_FRAMES / 3));

   game_state_e      st;
   logic             key_s1, key_s2, key_prev, key_rise;
   logic             hit_evt;
   logic             cnt_en, cnt_clear, cnt_done;
   logic [CNT_W-1:0] cnt_limit, cnt_next;
   logic [1:0]       cd_next;

   assign state   = st;
   assign hit_evt = collision_bird | bird_game_over;

   // Key synchronizer and registered rising-edge pulse (3 clk after the raw edge).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_s1   <= 1'b0;
         key_s2   <= 1'b0;
         key_prev <= 1'b0;
         key_rise <= 1'b0;
      end else begin
         key_s1   <= start_key;
         key_s2   <= key_s1;
         key_prev <= key_s2;
         key_rise <= key_s2 & ~key_prev;
      end
   end

   // Frame counter control: limit per state, clear on every state change.
   always_comb begin
      cnt_limit = READY_LIM;
      cnt_en    = 1'b0;
      cnt_clear = 1'b0;
      case (st)
         StIdle:  cnt_clear = key_rise;
         StReady: cnt_en    = start_of_frame;
         StPlay:  cnt_clear = hit_evt;
         StHit: begin
            cnt_limit = HIT_LIM;
            cnt_en    = start_of_frame;
         end
         StOver: begin
            cnt_limit = BLINK_LIM;
            cnt_en    = start_of_frame;
            cnt_clear = key_rise;
         end
         default: cnt_clear = 1'b1;
      endcase
   end

   // Countdown digit derived from the count that will be held after this clk.
   always_comb begin
      cd_next = 2'd1;
      if (cnt_next < THIRD_1) begin
         cd_next = 2'd3;
      end else if (cnt_next < THIRD_2) begin
         cd_next = 2'd2;
      end
   end

   frame_counter u_frame_counter (
      .clk        (clk),
      .reset      (reset),
      .clear      (cnt_clear),
      .enable     (cnt_en),
      .limit      (cnt_limit),
      .count_next (cnt_next),
      .done       (cnt_done)
   );

   // Round FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st          <= StIdle;
         bird_resetN <= 1'b0;
         move_enable <= 1'b0;
         score_bcd   <= '0;
         high_bcd    <= '0;
         show_over   <= 1'b0;
         countdown   <= 2'd3;
      end else begin
         case (st)
            StIdle: begin
               bird_resetN <= 1'b0;
               move_enable <= 1'b0;
               countdown   <= 2'd3;
               if (key_rise) begin
                  st          <= StReady;
                  score_bcd   <= '0;
                  bird_resetN <= 1'b1;
               end
            end
            StReady: begin
               if (cnt_done) begin
                  st          <= StPlay;
                  move_enable <= 1'b1;
                  countdown   <= 2'd3;
               end else begin
                  countdown <= cd_next;
               end
            end
            StPlay: begin
               // A pass on the collision clk still scores.
               if (pipe_passed) begin
                  score_bcd <= bcd_inc(score_bcd);
               end
               if (hit_evt) begin
                  st          <= StHit;
                  move_enable <= 1'b0;
               end
            end
            StHit: begin
               if (cnt_done) begin
                  st        <= StOver;
                  show_over <= 1'b1;
                  // Valid BCD orders the same as binary.
                  if (score_bcd > high_bcd) begin
                     high_bcd <= score_bcd;
                  end
               end
            end
            StOver: begin
               if (key_rise) begin
                  st          <= StIdle;
                  show_over   <= 1'b0;
                  bird_resetN <= 1'b0;
               end else if (cnt_done) begin
                  show_over <= ~show_over;
               end
            end
            default: begin
               st          <= StIdle;
               bird_resetN <= 1'b0;
               move_enable <= 1'b0;
               show_over   <= 1'b0;
               countdown   <= 2'd3;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short frame parameters.
module tb_game_flow_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_of_frame, start_key, collision_bird, bird_game_over, pipe_passed;
   logic       bird_resetN, move_enable, show_over;
   logic [7:0] score_bcd, high_bcd;
   logic [2:0] state;
   logic [1:0] countdown;

   int n_run  = 0;
   int n_fail = 0;

   logic [1:0] exp_cd [6];

   always #5 clk = ~clk;

   game_flow_ctrl #(
      .READY_FRAMES (6),
      .HIT_FRAMES   (3),
      .BLINK_FRAMES (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start_of_frame (start_of_frame),
      .start_key      (start_key),
      .collision_bird (collision_bird),
      .bird_game_over (bird_game_over),
      .pipe_passed    (pipe_passed),
      .bird_resetN    (bird_resetN),
      .move_enable    (move_enable),
      .score_bcd      (score_bcd),
      .high_bcd       (high_bcd),
      .state          (state),
      .show_over      (show_over),
      .countdown      (countdown)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic sof_pulse;
      start_of_frame = 1'b1;
      tick();
      start_of_frame = 1'b0;
   endtask

   task automatic pipes(input int n);
      for (int i = 0; i < n; i++) begin
         pipe_passed = 1'b1;
         tick();
         pipe_passed = 1'b0;
      end
   endtask

   // Press, hold until the round FSM has reacted, release, let the synchronizer settle.
   task automatic key_press;
      start_key = 1'b1;
      repeat (4) tick();
      start_key = 1'b0;
      repeat (3) tick();
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic start_play;
      key_press();
      repeat (6) sof_pulse();
   endtask

   task automatic collide_to_over;
      collision_bird = 1'b1;
      tick();
      collision_bird = 1'b0;
      repeat (3) sof_pulse();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) tick();
      n_run++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
      n_run++; if (bird_resetN !== 1'b0) begin n_fail++; $display("FAIL rst_bird_resetN: got %b want 0", bird_resetN); end
      n_run++; if (move_enable !== 1'b0) begin n_fail++; $display("FAIL rst_move: got %b want 0", move_enable); end
      n_run++; if (score_bcd !== 8'h00) begin n_fail++; $display("FAIL rst_score: got %h want 00", score_bcd); end
      n_run++; if (high_bcd !== 8'h00) begin n_fail++; $display("FAIL rst_high: got %h want 00", high_bcd); end
      n_run++; if (show_over !== 1'b0) begin n_fail++; $display("FAIL rst_show: got %b want 0", show_over); end
      n_run++; if (countdown !== 2'd3) begin n_fail++; $display("FAIL rst_countdown: got %0d want 3", countdown); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_key_start;
      start_key = 1'b1;
      repeat (3) tick();
      n_run++; if (state !== 3'd0) begin n_fail++; $display("FAIL key_early_state: got %0d want 0", state); end
      tick();
      n_run++; if (state !== 3'd1) begin n_fail++; $display("FAIL key_state: got %0d want 1", state); end
      n_run++; if (bird_resetN !== 1'b1) begin n_fail++; $display("FAIL key_bird_resetN: got %b want 1", bird_resetN); end
      n_run++; if (countdown !== 2'd3) begin n_fail++; $display("FAIL key_countdown: got %0d want 3", countdown); end
      n_run++; if (move_enable !== 1'b0) begin n_fail++; $display("FAIL key_move: got %b want 0", move_enable); end
      start_key = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_countdown;
      for (int i = 0; i < 6; i++) begin
         n_run++;
         if (countdown !== exp_cd[i] || state !== 3'd1) begin
            n_fail++;
            $display("FAIL countdown_%0d: got cd=%0d st=%0d want cd=%0d st=1", i, countdown, state,
                     exp_cd[i]);
         end
         sof_pulse();
      end
      n_run++; if (state !== 3'd2) begin n_fail++; $display("FAIL cd_play_state: got %0d want 2", state); end
      n_run++; if (move_enable !== 1'b1) begin n_fail++; $display("FAIL cd_play_move: got %b want 1", move_enable); end
   endtask

   task automatic test_score;
      pipes(9);
      n_run++; if (score_bcd !== 8'h09) begin n_fail++; $display("FAIL score_9: got %h want 09", score_bcd); end
      pipes(1);
      n_run++; if (score_bcd !== 8'h10) begin n_fail++; $display("FAIL score_10: got %h want 10", score_bcd); end
      pipes(89);
      n_run++; if (score_bcd !== 8'h99) begin n_fail++; $display("FAIL score_99: got %h want 99", score_bcd); end
      pipes(6);
      n_run++; if (score_bcd !== 8'h99) begin n_fail++; $display("FAIL score_sat: got %h want 99", score_bcd); end
      do_reset();
   endtask

   task automatic test_collision;
      key_press();
      // Collision during the countdown must not leave READY.
      collision_bird = 1'b1;
      bird_game_over = 1'b1;
      sof_pulse();
      collision_bird = 1'b0;
      bird_game_over = 1'b0;
      n_run++; if (state !== 3'd1) begin n_fail++; $display("FAIL ready_coll_state: got %0d want 1", state); end
      repeat (5) sof_pulse();
      pipes(7);
      n_run++; if (score_bcd !== 8'h07) begin n_fail++; $display("FAIL coll_pre_score: got %h want 07", score_bcd); end
      collision_bird = 1'b1;
      pipe_passed    = 1'b1;
      tick();
      collision_bird = 1'b0;
      pipe_passed    = 1'b0;
      n_run++; if (state !== 3'd3) begin n_fail++; $display("FAIL coll_state: got %0d want 3", state); end
      n_run++; if (score_bcd !== 8'h08) begin n_fail++; $display("FAIL coll_score: got %h want 08", score_bcd); end
      n_run++; if (move_enable !== 1'b0) begin n_fail++; $display("FAIL coll_move: got %b want 0", move_enable); end
      n_run++; if (bird_resetN !== 1'b1) begin n_fail++; $display("FAIL coll_bird_resetN: got %b want 1", bird_resetN); end
      repeat (2) sof_pulse();
      n_run++; if (state !== 3'd3) begin n_fail++; $display("FAIL hit_hold: got %0d want 3", state); end
      sof_pulse();
      n_run++; if (state !== 3'd4) begin n_fail++; $display("FAIL over_state: got %0d want 4", state); end
      n_run++; if (show_over !== 1'b1) begin n_fail++; $display("FAIL over_show_entry: got %b want 1", show_over); end
      n_run++; if (high_bcd !== 8'h08) begin n_fail++; $display("FAIL over_high: got %h want 08", high_bcd); end
      sof_pulse();
      n_run++; if (show_over !== 1'b1) begin n_fail++; $display("FAIL blink_1: got %b want 1", show_over); end
      sof_pulse();
      n_run++; if (show_over !== 1'b0) begin n_fail++; $display("FAIL blink_2: got %b want 0", show_over); end
      repeat (2) sof_pulse();
      n_run++; if (show_over !== 1'b1) begin n_fail++; $display("FAIL blink_4: got %b want 1", show_over); end
      pipes(1);
      n_run++; if (score_bcd !== 8'h08) begin n_fail++; $display("FAIL over_pipe_ignored: got %h want 08", score_bcd); end
      key_press();
      n_run++; if (state !== 3'd0) begin n_fail++; $display("FAIL over_exit_state: got %0d want 0", state); end
      n_run++; if (show_over !== 1'b0) begin n_fail++; $display("FAIL over_exit_show: got %b want 0", show_over); end
      n_run++; if (bird_resetN !== 1'b0) begin n_fail++; $display("FAIL over_exit_bird: got %b want 0", bird_resetN); end
   endtask

   task automatic test_high_score;
      start_play();
      pipes(12);
      collide_to_over();
      n_run++; if (high_bcd !== 8'h12) begin n_fail++; $display("FAIL high_r1: got %h want 12", high_bcd); end
      key_press();
      start_play();
      pipes(5);
      collide_to_over();
      n_run++; if (score_bcd !== 8'h05) begin n_fail++; $display("FAIL score_r2: got %h want 05", score_bcd); end
      n_run++; if (high_bcd !== 8'h12) begin n_fail++; $display("FAIL high_r2: got %h want 12", high_bcd); end
      key_press();
      start_play();
      pipes(20);
      collide_to_over();
      n_run++; if (high_bcd !== 8'h20) begin n_fail++; $display("FAIL high_r3: got %h want 20", high_bcd); end
      key_press();
   endtask

   task automatic test_mid_reset;
      start_play();
      pipes(3);
      key_press();
      n_run++; if (state !== 3'd2) begin n_fail++; $display("FAIL play_key_ignored: got %0d want 2", state); end
      n_run++; if (score_bcd !== 8'h03) begin n_fail++; $display("FAIL play_key_score: got %h want 03", score_bcd); end
      // Assert reset between clock edges and look before the next edge.
      #3;
      reset = 1'b1;
      #1;
      n_run++; if (score_bcd !== 8'h00) begin n_fail++; $display("FAIL async_score: got %h want 00", score_bcd); end
      n_run++; if (high_bcd !== 8'h00) begin n_fail++; $display("FAIL async_high: got %h want 00", high_bcd); end
      n_run++; if (bird_resetN !== 1'b0) begin n_fail++; $display("FAIL async_bird: got %b want 0", bird_resetN); end
      n_run++; if (state !== 3'd0) begin n_fail++; $display("FAIL async_state: got %0d want 0", state); end
      #2;
      reset = 1'b0;
      tick();
   endtask

   initial begin
      exp_cd[0] = 2'd3; exp_cd[1] = 2'd3; exp_cd[2] = 2'd2;
      exp_cd[3] = 2'd2; exp_cd[4] = 2'd1; exp_cd[5] = 2'd1;
      reset          = 1'b1;
      start_of_frame = 1'b0;
      start_key      = 1'b0;
      collision_bird = 1'b0;
      bird_game_over = 1'b0;
      pipe_passed    = 1'b0;
      test_reset();
      test_key_start();
      test_countdown();
      test_score();
      test_collision();
      test_high_score();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
